// File: rtl/adc_spi_cfg_multi.sv
// adc_spi_cfg_multi: queued SPI configuration master, one frame per command to every ADC in its mask.
// Latency: pop to done = 1 + CLK_DIV*(2*FRAME_W+2) cycles, then GAP_CYC cycles of CS high before the next pop.
// Backpressure: cmd_ready low while the FIFO is full, unless a pop frees a slot in the same cycle.
module adc_spi_cfg_multi #(
    parameter int               NUM_ADC = 2,
    parameter int               ADDR_W  = 4,
    parameter int               DATA_W  = 16,
    parameter int               HDR_W   = 12,
    parameter logic [HDR_W-1:0] HDR     = 'h001,
    parameter int               CLK_DIV = 4,
    parameter int               GAP_CYC = 8,
    parameter int               FIFO_AW = 2
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [NUM_ADC-1:0] cmd_mask,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [DATA_W-1:0]  cmd_data,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               busy,
    output logic               done,
    output logic [NUM_ADC-1:0] adc_sclk,
    output logic [NUM_ADC-1:0] adc_notSCS,
    output logic [NUM_ADC-1:0] adc_sdata
);

    localparam int FRAME_W = HDR_W + ADDR_W + DATA_W;
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int HP_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef struct packed {
        logic [NUM_ADC-1:0] mask;
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  data;
    } cmd_t;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

    // ---------------- command FIFO ----------------
    cmd_t             mem_q [DEPTH];
    cmd_t             cmd_in;
    cmd_t             head;
    logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0] level;
    logic             fifo_empty, fifo_full, push, pop;

    state_t               state_q, state_d;
    logic [HP_W-1:0]      hp_q, hp_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic                 phase_q, phase_d;    // 0: SCLK low half, 1: SCLK high half
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [NUM_ADC-1:0]   mask_q, mask_d;
    logic [NUM_ADC-1:0]   sclk_q, sclk_d;
    logic [NUM_ADC-1:0]   cs_q, cs_d;
    logic [NUM_ADC-1:0]   sdata_q, sdata_d;
    logic                 done_q, done_d;
    logic                 hp_last, bit_last, gap_last;

    assign cmd_in     = {cmd_mask, cmd_addr, cmd_data};
    assign level      = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == (FIFO_AW+1)'(DEPTH));
    assign pop        = (state_q == S_IDLE) && !fifo_empty;
    // A pop in this cycle frees the slot the incoming push lands in.
    assign cmd_ready  = !fifo_full || pop;
    assign push       = cmd_valid && cmd_ready;
    assign head       = mem_q[rd_ptr_q[FIFO_AW-1:0]];

    // FIFO pointers; reset drops every queued command.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= cmd_in;
    end

    // ---------------- frame sequencer ----------------
    assign hp_last  = (hp_q == HP_W'(CLK_DIV - 1));
    assign bit_last = (bit_q == BIT_W'(FRAME_W - 1));
    assign gap_last = (gap_q == GAP_W'(GAP_CYC - 1));

    // State and datapath register.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            hp_q    <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
            gap_q   <= '0;
            frame_q <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            gap_q   <= gap_d;
            frame_q <= frame_d;
            mask_q  <= mask_d;
        end
    end

    // Next-state: hp paces every phase; bit/phase walk the frame; gap times CS-high idle.
    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        gap_d   = gap_q;
        frame_d = frame_q;
        mask_d  = mask_q;
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    frame_d = {HDR, head.addr, head.data};
                    mask_d  = head.mask;
                    hp_d    = '0;
                    if (head.mask != '0) state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                hp_d = hp_last ? '0 : hp_q + 1'b1;
                if (hp_last) begin
                    state_d = S_SHIFT;
                    bit_d   = '0;
                    phase_d = 1'b0;
                end
            end
            S_SHIFT: begin
                hp_d = hp_last ? '0 : hp_q + 1'b1;
                if (hp_last) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else if (bit_last) begin
                        state_d = S_HOLD;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        phase_d = 1'b0;
                        frame_d = {frame_q[FRAME_W-2:0], 1'b0};
                    end
                end
            end
            S_HOLD: begin
                hp_d = hp_last ? '0 : hp_q + 1'b1;
                if (hp_last) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                end
            end
            S_GAP: begin
                if (gap_last) state_d = S_IDLE;
                else          gap_d   = gap_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pin next values: change only at phase boundaries, gated by the latched mask.
    always_comb begin
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        sdata_d = sdata_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    sclk_d  = '1;
                    sdata_d = '0;
                    if (head.mask == '0) done_d = 1'b1;
                    else                 cs_d   = ~head.mask;
                end
            end
            S_SETUP: begin
                if (hp_last) begin
                    sclk_d  = ~mask_q;
                    sdata_d = mask_q & {NUM_ADC{frame_q[FRAME_W-1]}};
                end
            end
            S_SHIFT: begin
                if (hp_last) begin
                    if (!phase_q) begin
                        sclk_d = '1;
                    end else if (!bit_last) begin
                        sclk_d  = ~mask_q;
                        sdata_d = mask_q & {NUM_ADC{frame_q[FRAME_W-2]}};
                    end
                end
            end
            S_HOLD: begin
                if (hp_last) begin
                    sclk_d  = '1;
                    cs_d    = '1;
                    sdata_d = '0;
                    done_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output registers so the pins never see combinational paths from cmd_*.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            sclk_q  <= '1;
            cs_q    <= '1;
            sdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            sdata_q <= sdata_d;
            done_q  <= done_d;
        end
    end

    assign adc_sclk   = sclk_q;
    assign adc_notSCS = cs_q;
    assign adc_sdata  = sdata_q;
    assign done       = done_q;
    assign busy       = (state_q != S_IDLE) || !fifo_empty;
    assign fifo_level = level;

endmodule

// File: tb/tb_adc_spi_cfg_multi.sv
// Bench for adc_spi_cfg_multi: DUT A (2 ADCs, CLK_DIV=2) and DUT B (4 ADCs, CLK_DIV=1), GAP_CYC=4.
// Pins are sampled on the falling sys_clk edge; ADC capture is modelled on rising SCLK with CS low.
// Expected frames and latencies are hand-computed constants.
module tb_adc_spi_cfg_multi;

    localparam int CDA = 2;
    localparam int GAP = 4;
    localparam int LAT_A = 1 + CDA * 66;     // 133
    localparam int LAT_B = 1 + 1 * 66;       // 67

    logic sys_clk = 1'b0;
    logic reset;
    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    logic        a_valid, a_ready, a_busy, a_done;
    logic [1:0]  a_mask, a_sclk, a_cs, a_sdat;
    logic [3:0]  a_addr;
    logic [15:0] a_data;
    logic [2:0]  a_level;

    logic        b_valid, b_ready, b_busy, b_done;
    logic [3:0]  b_mask, b_sclk, b_cs, b_sdat;
    logic [3:0]  b_addr;
    logic [15:0] b_data;
    logic [2:0]  b_level;

    adc_spi_cfg_multi #(.NUM_ADC(2), .CLK_DIV(CDA), .GAP_CYC(GAP)) dut_a (
        .sys_clk(sys_clk), .reset(reset),
        .cmd_valid(a_valid), .cmd_ready(a_ready),
        .cmd_mask(a_mask), .cmd_addr(a_addr), .cmd_data(a_data),
        .fifo_level(a_level), .busy(a_busy), .done(a_done),
        .adc_sclk(a_sclk), .adc_notSCS(a_cs), .adc_sdata(a_sdat)
    );

    adc_spi_cfg_multi #(.NUM_ADC(4), .CLK_DIV(1), .GAP_CYC(GAP)) dut_b (
        .sys_clk(sys_clk), .reset(reset),
        .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_mask(b_mask), .cmd_addr(b_addr), .cmd_data(b_data),
        .fifo_level(b_level), .busy(b_busy), .done(b_done),
        .adc_sclk(b_sclk), .adc_notSCS(b_cs), .adc_sdata(b_sdat)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // ---------------- ADC-side model ----------------
    typedef struct { int adc; logic [31:0] w; int n; } frm_t;
    frm_t        frm_q[$];
    int          done_q[$];
    logic [31:0] cap [4];
    int          nbits [4];
    int          falls [4];
    int          highs [4];
    int          last_rise [4];
    int          rise_cyc [4];
    int          per_err;
    int          min_gap;
    logic [3:0]  ps, pc;

    task automatic mon_clear();
        for (int i = 0; i < 4; i++) begin
            cap[i] = '0; nbits[i] = 0; falls[i] = 0; highs[i] = 0;
            last_rise[i] = 0; rise_cyc[i] = -1;
        end
        frm_q.delete();
        done_q.delete();
        per_err = 0;
        min_gap = 1000000;
        ps = '1;
        pc = '1;
    endtask

    task automatic collect(input bit sel, input int target, input int budget);
        logic [3:0] s, c, d;
        logic       dn;
        int         cdiv;
        frm_t       f;
        cdiv = sel ? 1 : CDA;
        for (int k = 0; k < budget && done_q.size() < target; k++) begin
            @(negedge sys_clk);
            if (sel) begin
                s = b_sclk; c = b_cs; d = b_sdat; dn = b_done;
            end else begin
                s = {2'b11, a_sclk}; c = {2'b11, a_cs}; d = {2'b00, a_sdat}; dn = a_done;
            end
            for (int i = 0; i < 4; i++) begin
                if (!c[i] && s[i] && !ps[i]) begin
                    if (nbits[i] > 0 && (cyc - last_rise[i]) != 2 * cdiv) per_err++;
                    last_rise[i] = cyc;
                    cap[i] = {cap[i][30:0], d[i]};
                    nbits[i]++;
                end
                if (!s[i] && ps[i]) falls[i]++;
                if (d[i]) highs[i]++;
                if (c[i] && !pc[i]) begin
                    f.adc = i; f.w = cap[i]; f.n = nbits[i];
                    frm_q.push_back(f);
                    cap[i] = '0; nbits[i] = 0; rise_cyc[i] = cyc;
                end
                if (!c[i] && pc[i] && rise_cyc[i] >= 0 && (cyc - rise_cyc[i]) < min_gap)
                    min_gap = cyc - rise_cyc[i];
            end
            if (dn) done_q.push_back(cyc);
            ps = s;
            pc = c;
        end
    endtask

    task automatic push_cmd(input bit sel, input logic [3:0] m, input logic [3:0] ad,
                            input logic [15:0] dt, input int budget, output int t, output bit ok);
        @(negedge sys_clk);
        if (sel) begin b_mask = m; b_addr = ad; b_data = dt; b_valid = 1'b1; end
        else     begin a_mask = m[1:0]; a_addr = ad; a_data = dt; a_valid = 1'b1; end
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (sel ? b_ready : a_ready) begin ok = 1'b1; break; end
            @(negedge sys_clk);
        end
        t = cyc;
        @(posedge sys_clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit sel, input int budget);
        int k;
        k = 0;
        @(negedge sys_clk);
        while ((sel ? b_busy : a_busy) && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
        chk("idle_reached", 32'(sel ? b_busy : a_busy), 32'd0);
    endtask

    typedef struct { logic [1:0] mask; logic [3:0] addr; logic [15:0] data; logic [31:0] exp; } vec_t;
    vec_t vecs [5];

    int          t, t1, wait_n;
    bit          ok, ok6;
    logic        rec_ready_full;
    logic [2:0]  rec_level_full, rec_level_after;
    int          idx [2];
    int          found;
    logic [31:0] exp_w;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b01, 4'h1, 16'hB2FF, 32'h0011B2FF};
        vecs[1] = '{2'b10, 4'hA, 16'h5A5A, 32'h001A5A5A};
        vecs[2] = '{2'b11, 4'hF, 16'hFFFF, 32'h001FFFFF};
        vecs[3] = '{2'b11, 4'h0, 16'h0000, 32'h00100000};
        vecs[4] = '{2'b01, 4'h3, 16'h8001, 32'h00138001};

        a_valid = 0; a_mask = '0; a_addr = '0; a_data = '0;
        b_valid = 0; b_mask = '0; b_addr = '0; b_data = '0;
        reset = 1'b1;
        repeat (3) @(negedge sys_clk);

        // Reset state
        chk("rst_a_sclk",  32'(a_sclk), 32'h3);
        chk("rst_a_cs",    32'(a_cs),   32'h3);
        chk("rst_a_sdat",  32'(a_sdat), 32'h0);
        chk("rst_a_done",  32'(a_done), 32'h0);
        chk("rst_a_busy",  32'(a_busy), 32'h0);
        chk("rst_a_level", 32'(a_level), 32'h0);
        chk("rst_a_ready", 32'(a_ready), 32'h1);
        chk("rst_b_sclk",  32'(b_sclk), 32'hF);
        chk("rst_b_cs",    32'(b_cs),   32'hF);
        reset = 1'b0;
        @(negedge sys_clk);

        // Single frames from the vector table
        for (int v = 0; v < 5; v++) begin
            mon_clear();
            push_cmd(1'b0, {2'b00, vecs[v].mask}, vecs[v].addr, vecs[v].data, 10, t, ok);
            chk($sformatf("v%0d_accept", v), 32'(ok), 32'd1);
            collect(1'b0, 1, 400);
            chk($sformatf("v%0d_done_cnt", v), 32'(done_q.size()), 32'd1);
            if (done_q.size() > 0)
                chk($sformatf("v%0d_done_lat", v), 32'(done_q[0] - t), 32'(LAT_A + 1));
            for (int i = 0; i < 2; i++) begin
                found = 0;
                foreach (frm_q[j]) begin
                    if (frm_q[j].adc == i) begin
                        found++;
                        chk($sformatf("v%0d_adc%0d_word", v, i), frm_q[j].w, vecs[v].exp);
                        chk($sformatf("v%0d_adc%0d_bits", v, i), 32'(frm_q[j].n), 32'd32);
                    end
                end
                if (vecs[v].mask[i]) begin
                    chk($sformatf("v%0d_adc%0d_frames", v, i), 32'(found), 32'd1);
                    chk($sformatf("v%0d_adc%0d_falls", v, i), 32'(falls[i]), 32'd32);
                end else begin
                    chk($sformatf("v%0d_adc%0d_frames", v, i), 32'(found), 32'd0);
                    chk($sformatf("v%0d_adc%0d_quiet", v, i), 32'(falls[i] + highs[i]), 32'd0);
                end
            end
            chk($sformatf("v%0d_sclk_period", v), 32'(per_err), 32'd0);
            wait_idle(1'b0, 50);
            chk($sformatf("v%0d_level_end", v), 32'(a_level), 32'd0);
        end

        // Back-to-back commands, FIFO fill, stall, push coinciding with pop while full
        mon_clear();
        fork
            begin
                push_cmd(1'b0, 4'b0011, 4'd0, 16'hA500, 10, t1, ok);
                for (int j = 1; j < 5; j++)
                    push_cmd(1'b0, 4'b0011, 4'(j), 16'hA500 + 16'(j), 10, t, ok);
                @(negedge sys_clk);
                rec_ready_full = a_ready;
                rec_level_full = a_level;
                wait_n = cyc;
                push_cmd(1'b0, 4'b0011, 4'd5, 16'hA505, 400, t, ok6);
                wait_n = t - wait_n;
                @(negedge sys_clk);
                rec_level_after = a_level;
            end
            collect(1'b0, 6, 1500);
        join
        chk("full_ready_low", 32'(rec_ready_full), 32'd0);
        chk("full_level",     32'(rec_level_full), 32'd4);
        chk("stall_accept",   32'(ok6), 32'd1);
        chk("stall_waited",   32'(wait_n > 100), 32'd1);
        chk("pushpop_level",  32'(rec_level_after), 32'd4);
        chk("b2b_done_cnt",   32'(done_q.size()), 32'd6);
        if (done_q.size() > 0) chk("b2b_first_lat", 32'(done_q[0] - t1), 32'(LAT_A + 1));
        for (int j = 1; j < done_q.size(); j++)
            chk($sformatf("b2b_done_gap%0d", j), 32'(done_q[j] - done_q[j-1]), 32'(LAT_A + GAP));
        chk("b2b_cs_gap_ok", 32'(min_gap >= GAP + 1), 32'd1);
        chk("b2b_frames", 32'(frm_q.size()), 32'd12);
        idx[0] = 0; idx[1] = 0;
        foreach (frm_q[j]) begin
            if (frm_q[j].adc < 2) begin
                exp_w = {12'h001, 4'(idx[frm_q[j].adc]), 16'hA500 + 16'(idx[frm_q[j].adc])};
                chk($sformatf("b2b_adc%0d_f%0d", frm_q[j].adc, idx[frm_q[j].adc]), frm_q[j].w, exp_w);
                idx[frm_q[j].adc]++;
            end
        end
        wait_idle(1'b0, 50);

        // mask = 0: no pin activity, done two cycles after push, busy drops
        mon_clear();
        push_cmd(1'b0, 4'b0000, 4'h7, 16'h1234, 10, t, ok);
        collect(1'b0, 1, 20);
        chk("m0_done_cnt", 32'(done_q.size()), 32'd1);
        if (done_q.size() > 0) chk("m0_done_lat", 32'(done_q[0] - t), 32'd2);
        chk("m0_busy", 32'(a_busy), 32'd0);
        chk("m0_quiet", 32'(falls[0] + falls[1] + highs[0] + highs[1] + frm_q.size()), 32'd0);
        @(negedge sys_clk);
        chk("m0_done_pulse", 32'(a_done), 32'd0);

        // Reset mid-frame (bit 10) with commands queued
        push_cmd(1'b0, 4'b0011, 4'h9, 16'hFFFF, 10, t1, ok);
        push_cmd(1'b0, 4'b0011, 4'h1, 16'h1111, 10, t, ok);
        push_cmd(1'b0, 4'b0011, 4'h2, 16'h2222, 10, t, ok);
        while (cyc < t1 + 45) @(negedge sys_clk);
        chk("mid_cs_low", 32'(a_cs), 32'h0);
        chk("mid_level",  32'(a_level), 32'd2);
        reset = 1'b1;
        #1;
        chk("rst_mid_cs",    32'(a_cs),    32'h3);
        chk("rst_mid_sclk",  32'(a_sclk),  32'h3);
        chk("rst_mid_sdat",  32'(a_sdat),  32'h0);
        chk("rst_mid_level", 32'(a_level), 32'd0);
        chk("rst_mid_busy",  32'(a_busy),  32'd0);
        repeat (2) @(negedge sys_clk);
        reset = 1'b0;
        mon_clear();
        collect(1'b0, 1, 300);
        chk("rst_no_done", 32'(done_q.size()), 32'd0);
        chk("rst_no_sclk", 32'(falls[0] + falls[1]), 32'd0);

        // DUT B: CLK_DIV=1, four ADCs, mask 1010
        mon_clear();
        push_cmd(1'b1, 4'b1010, 4'h6, 16'h1234, 10, t, ok);
        collect(1'b1, 1, 200);
        chk("b_done_cnt", 32'(done_q.size()), 32'd1);
        if (done_q.size() > 0) chk("b_done_lat", 32'(done_q[0] - t), 32'(LAT_B + 1));
        chk("b_sclk_period", 32'(per_err), 32'd0);
        chk("b_frames", 32'(frm_q.size()), 32'd2);
        foreach (frm_q[j]) begin
            chk($sformatf("b_adc%0d_word", frm_q[j].adc), frm_q[j].w, 32'h00161234);
            chk($sformatf("b_adc%0d_sel", frm_q[j].adc), 32'(frm_q[j].adc == 1 || frm_q[j].adc == 3), 32'd1);
        end
        chk("b_adc1_falls", 32'(falls[1]), 32'd32);
        chk("b_adc3_falls", 32'(falls[3]), 32'd32);
        chk("b_quiet_0_2", 32'(falls[0] + falls[2] + highs[0] + highs[2]), 32'd0);
        wait_idle(1'b1, 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
